// File: rtl/codec_pkg.sv
// Shared widths, FSM state encoding and phase-counter helper for the
// codec sequencing controller and its tap line.
package codec_pkg;

    localparam int W     = 8;
    localparam int CNT_W = 16;
    localparam int PH_W  = 8;   // phase counter width; phase lengths up to 2**PH_W cycles

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ENC  = 3'd1,
        ST_DEC  = 3'd2,
        ST_FILT = 3'd3,
        ST_OUT  = 3'd4
    } state_t;

    // A phase of N cycles starts its down-counter at N-1 and ends when it reads 0.
    function automatic logic [PH_W-1:0] phase_load(input int cycles);
        return PH_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/codec_tap_line.sv
// Four-deep signed history line feeding the filter; newest value in tap0.
// Shifts on command, clears synchronously, and resets asynchronously.
module codec_tap_line
    import codec_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         shift,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic [W-1:0] tap0,
    output logic [W-1:0] tap1,
    output logic [W-1:0] tap2,
    output logic [W-1:0] tap3
);

    // NOTE: every register is in the reset list; the line is only four words, so no memory-style un-reset storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap0 <= '0;
            tap1 <= '0;
            tap2 <= '0;
            tap3 <= '0;
        end else if (clear) begin
            tap0 <= '0;
            tap1 <= '0;
            tap2 <= '0;
            tap3 <= '0;
        end else if (shift) begin
            tap3 <= tap2;
            tap2 <= tap1;
            tap1 <= tap0;
            tap0 <= din;
        end
    end

endmodule

// File: rtl/codec_seq_ctrl.sv
// Runs one sample at a time through encode, decode and filter phases,
// keeps the filter history and returns the filtered result via valid/ready.
module codec_seq_ctrl
    import codec_pkg::*;
#(
    parameter int ENC_CYCLES  = 8,
    parameter int DEC_CYCLES  = 8,
    parameter int FILT_CYCLES = 2
) (
    input  logic             CLK100MHZ,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             clear_hist,
    output logic             enc_start,
    output logic [W-1:0]     enc_data,
    output logic [W-1:0]     enc_delay,
    output logic             dec_start,
    input  logic [W-1:0]     dec_result,
    output logic [W-1:0]     filt_current,
    output logic [W-1:0]     filt_delay,
    output logic [W-1:0]     filt_delay2,
    output logic [W-1:0]     filt_delay3,
    input  logic [W-1:0]     filt_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             err_sticky,
    output logic [CNT_W-1:0] frame_count
);

    state_t          state;
    logic [PH_W-1:0] phase_cnt;
    logic            phase_last;
    logic            tap_shift;
    logic            tap_clear;

    assign phase_last = (phase_cnt == '0);
    // History moves on the final decode cycle; clearing is honoured only while idle.
    assign tap_shift  = (state == ST_DEC) && phase_last;
    assign tap_clear  = (state == ST_IDLE) && clear_hist;

    codec_tap_line u_tap_line (
        .clk   (CLK100MHZ),
        .rst   (reset),
        .shift (tap_shift),
        .clear (tap_clear),
        .din   (dec_result),
        .tap0  (filt_current),
        .tap1  (filt_delay),
        .tap2  (filt_delay2),
        .tap3  (filt_delay3)
    );

    // NOTE: all state and outputs update with non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            phase_cnt   <= '0;
            in_ready    <= 1'b0;
            enc_start   <= 1'b0;
            enc_data    <= '0;
            enc_delay   <= '0;
            dec_start   <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            err_sticky  <= 1'b0;
            frame_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    if (clear_hist) begin
                        err_sticky <= 1'b0;
                        enc_data   <= '0;
                        enc_delay  <= '0;
                    end
                    if (in_valid && in_ready) begin
                        // A same-cycle clear wins for the delay word; the new sample still loads.
                        enc_delay <= clear_hist ? '0 : enc_data;
                        enc_data  <= in_data;
                        in_ready  <= 1'b0;
                        enc_start <= 1'b1;
                        phase_cnt <= phase_load(ENC_CYCLES);
                        state     <= ST_ENC;
                    end
                end

                ST_ENC: begin
                    if (phase_last) begin
                        enc_start <= 1'b0;
                        dec_start <= 1'b1;
                        phase_cnt <= phase_load(DEC_CYCLES);
                        state     <= ST_DEC;
                    end else begin
                        phase_cnt <= phase_cnt - PH_W'(1);
                    end
                end

                ST_DEC: begin
                    if (phase_last) begin
                        dec_start  <= 1'b0;
                        err_sticky <= err_sticky | (dec_result != enc_data);
                        phase_cnt  <= phase_load(FILT_CYCLES);
                        state      <= ST_FILT;
                    end else begin
                        phase_cnt <= phase_cnt - PH_W'(1);
                    end
                end

                ST_FILT: begin
                    if (phase_last) begin
                        out_data  <= filt_result;
                        out_valid <= 1'b1;
                        state     <= ST_OUT;
                    end else begin
                        phase_cnt <= phase_cnt - PH_W'(1);
                    end
                end

                ST_OUT: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        frame_count <= frame_count + CNT_W'(1);
                        in_ready    <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b0;
                    enc_start <= 1'b0;
                    dec_start <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
